cordic_vector_engine: RTL and testbench



---
 rtl/cordic_vector_engine_if.sv | 23 ++
 rtl/cordic_vector_engine.sv | 128 ++++++++++++
 tb/tb_cordic_vector_engine.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/cordic_vector_engine_if.sv
// Host-side bundle for the vectoring CORDIC engine: start/busy/done handshake,
// Cartesian inputs, and magnitude/angle results.
interface cordic_vector_engine_if #(
  parameter int XY_W = 16
) ();
  logic                  start;
  logic signed [XY_W-1:0] x_in;
  logic signed [XY_W-1:0] y_in;
  logic                  busy;
  logic                  done;
  logic [XY_W:0]         mag_out;
  logic signed [XY_W+1:0] angle_out;

  modport master (
    output start, x_in, y_in,
    input  busy, done, mag_out, angle_out
  );

  modport slave (
    input  start, x_in, y_in,
    output busy, done, mag_out, angle_out
  );
endinterface

// File: rtl/cordic_vector_engine.sv
// Iterative vectoring-mode CORDIC: (x, y) -> magnitude and angle in degrees x256.
// Optional macro CORDIC_GAIN_COMP_EN scales the magnitude by ~1/1.6468 at FINISH.
//
// state  | meaning
// IDLE   | waiting for start; pre-rotates and loads the operands on accept
// RUN    | one micro-rotation per cycle, iterations 0..ITERS-1
// FINISH | publish magnitude/angle, pulse done, return to IDLE
module cordic_vector_engine #(
  parameter int ITERS = 16,
  parameter int XY_W  = 16
) (
  input logic                   clk,
  input logic                   reset,
  cordic_vector_engine_if.slave bus
);
  localparam int W = XY_W + 2;
  localparam int ATAN_TAB [16] = '{11520, 6801, 3593, 1824, 916, 458, 229, 115,
                                    57, 29, 14, 7, 4, 2, 1, 0};
  localparam int ANG_90 = 23040;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t state, state_next;

  logic [3:0]          iter;
  logic signed [W-1:0] x, y, z;
  logic signed [W-1:0] x_ext, y_ext;
  logic signed [W-1:0] x_ld, y_ld, z_ld;
  logic signed [W-1:0] x_sh, y_sh, t_ang;
  logic [XY_W:0]       mag_val;
  logic [XY_W:0]       mag_q;
  logic signed [W-1:0] angle_q;
  logic                done_q;
  logic                last_iter;

  assign x_ext     = $signed({{2{bus.x_in[XY_W-1]}}, bus.x_in});
  assign y_ext     = $signed({{2{bus.y_in[XY_W-1]}}, bus.y_in});
  assign x_sh      = x >>> iter;
  assign y_sh      = y >>> iter;
  assign t_ang     = W'(ATAN_TAB[iter]);
  assign last_iter = (iter == 4'(ITERS - 1));

  // Left-half-plane inputs are turned by +/-90 degrees so the iterations converge.
  always_comb begin
    x_ld = x_ext;
    y_ld = y_ext;
    z_ld = '0;
    if (x_ext < 0) begin
      if (y_ext >= 0) begin
        x_ld = y_ext;
        y_ld = -x_ext;
        z_ld = W'(ANG_90);
      end else begin
        x_ld = -y_ext;
        y_ld = x_ext;
        z_ld = -W'(ANG_90);
      end
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  assign mag_val = (XY_W+1)'((x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9));
`else
  assign mag_val = x[XY_W:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_iter) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iter    <= '0;
      x       <= '0;
      y       <= '0;
      z       <= '0;
      mag_q   <= '0;
      angle_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            x    <= x_ld;
            y    <= y_ld;
            z    <= z_ld;
            iter <= '0;
          end
        end
        RUN: begin
          if (y >= 0) begin
            x <= x + y_sh;
            y <= y - x_sh;
            z <= z + t_ang;
          end else begin
            x <= x - y_sh;
            y <= y + x_sh;
            z <= z - t_ang;
          end
          iter <= iter + 4'd1;
        end
        FINISH: begin
          mag_q   <= mag_val;
          angle_q <= z;
          done_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.mag_out   = mag_q;
  assign bus.angle_out = angle_q;
endmodule

// File: tb/tb_cordic_vector_engine.sv
// Scoreboard bench for cordic_vector_engine: expected magnitude/angle/latency come
// from real-valued sqrt/atan2 and are popped by a monitor on every done pulse.
module tb_cordic_vector_engine;
  localparam int XY_W  = 16;
  localparam int ITERS = 16;

  typedef struct {
    int  xi;
    int  yi;
    real mag;
    real ang;
    int  mag_tol;
    int  ang_tol;
    int  due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  real  gain_k;
  exp_t sb[$];
  logic prev_done = 1'b0;

  cordic_vector_engine_if #(.XY_W(XY_W)) bus ();

  cordic_vector_engine #(.ITERS(ITERS), .XY_W(XY_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input bit ok, input longint act, input longint req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d, wanted %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t make_exp(input int xi, input int yi, input int mt, input int at,
                                    input int due);
    exp_t e;
    real  m;
    m = $sqrt(real'(xi) * real'(xi) + real'(yi) * real'(yi)) * gain_k;
`ifdef CORDIC_GAIN_COMP_EN
    m = m * 0.607421875;
`endif
    e.xi = xi; e.yi = yi; e.mag = m;
    e.ang = $atan2(real'(yi), real'(xi)) * 180.0 / 3.14159265358979 * 256.0;
    e.mag_tol = mt; e.ang_tol = at; e.due = due;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset && bus.done) begin
      exp_t e;
      real  dm, da;
      int   ma, aa;
      chk("done_single_cycle", !prev_done, longint'(prev_done), 0);
      chk("busy_low_at_done", !bus.busy, longint'(bus.busy), 0);
      chk("done_expected", sb.size() != 0, 1, longint'(sb.size() != 0));
      if (sb.size() != 0) begin
        e  = sb.pop_front();
        ma = int'(bus.mag_out);
        aa = int'(bus.angle_out);
        dm = real'(ma) - e.mag;
        da = real'(aa) - e.ang;
        while (da > 46080.0)  da = da - 92160.0;
        while (da < -46080.0) da = da + 92160.0;
        chk($sformatf("mag(%0d,%0d)", e.xi, e.yi), dm <= e.mag_tol && dm >= -e.mag_tol,
            ma, $rtoi(e.mag + 0.5));
        chk($sformatf("angle(%0d,%0d)", e.xi, e.yi), da <= e.ang_tol && da >= -e.ang_tol,
            aa, $rtoi(e.ang));
        chk($sformatf("latency(%0d,%0d)", e.xi, e.yi), cyc == e.due, cyc, e.due);
      end
    end
    prev_done = bus.done;
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 1'b0, n, 100);
  endtask

  task automatic issue(input int xi, input int yi, input int mt, input int at);
    wait_idle();
    bus.start = 1'b1;
    bus.x_in  = 16'(xi);
    bus.y_in  = 16'(yi);
    @(posedge clk);
    #1;
    sb.push_back(make_exp(xi, yi, mt, at, cyc + ITERS + 1));
    bus.start = 1'b0;
    bus.x_in  = 16'($urandom());
    bus.y_in  = 16'($urandom());
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size() == 0, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    gain_k = 1.0;
    for (int i = 0; i < ITERS; i++) gain_k = gain_k * $sqrt(1.0 + 1.0 / real'(4 ** i));

    reset = 1'b1;
    bus.start = 1'b0;
    bus.x_in  = '0;
    bus.y_in  = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", bus.busy == 1'b0, longint'(bus.busy), 0);
    chk("reset_done", bus.done == 1'b0, longint'(bus.done), 0);
    chk("reset_mag", bus.mag_out == '0, longint'(bus.mag_out), 0);
    chk("reset_angle", bus.angle_out == '0, longint'(bus.angle_out), 0);
    reset = 1'b0;

    // directed vectors, including both pre-rotation quadrants
    issue(16384, 0, 8, 16);
    issue(1000, 1000, 8, 16);
    issue(-1000, 0, 8, 16);
    issue(0, -5000, 8, 16);
    issue(-12000, -9000, 8, 16);
    drain();

    // start held high: accepts only when idle; mid-run input change affects the next one only
    wait_idle();
    bus.start = 1'b1;
    bus.x_in  = 16'(1000);
    bus.y_in  = 16'(1000);
    @(posedge clk);
    #1;
    a = cyc;
    sb.push_back(make_exp(1000, 1000, 8, 16, a + 17));
    sb.push_back(make_exp(16384, 0, 8, 16, a + 35));
    sb.push_back(make_exp(16384, 0, 8, 16, a + 53));
    while (cyc < a + 8) @(negedge clk);
    bus.x_in = 16'(16384);
    bus.y_in = 16'(0);
    while (cyc < a + 36) @(negedge clk);
    bus.start = 1'b0;
    drain();

    // reset during RUN iteration 7 aborts with cleared outputs
    wait_idle();
    bus.start = 1'b1;
    bus.x_in  = 16'(3000);
    bus.y_in  = 16'(-2000);
    @(posedge clk);
    #1;
    a = cyc;
    bus.start = 1'b0;
    while (cyc < a + 7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", bus.busy == 1'b0, longint'(bus.busy), 0);
    chk("abort_done", bus.done == 1'b0, longint'(bus.done), 0);
    chk("abort_mag", bus.mag_out == '0, longint'(bus.mag_out), 0);
    chk("abort_angle", bus.angle_out == '0, longint'(bus.angle_out), 0);
    issue(1000, 1000, 8, 16);

    for (int k = 0; k < 24; k++) begin
      int xi, yi;
      xi = 0;
      yi = 0;
      for (int t = 0; t < 100; t++) begin
        xi = int'($signed(16'($urandom())));
        yi = int'($signed(16'($urandom())));
        if (longint'(xi) * xi + longint'(yi) * yi >= 64000000) break;
      end
      issue(xi, yi, 16, 32);
    end
    drain();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
